// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access unit: request kinds, CSR ops, addresses, trap codes, FSM states.
// Also holds the write/read-performed decode shared by the top and its legality check.
package csr_pkg;

  localparam logic [1:0] KIND_CSR    = 2'b00;
  localparam logic [1:0] KIND_ECALL  = 2'b01;
  localparam logic [1:0] KIND_EBREAK = 2'b10;
  localparam logic [1:0] KIND_MRET   = 2'b11;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MISA    = 12'h301;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_INSTRET = 12'hC02;

  localparam logic [31:0] DEF_ILLEGAL_CODE = 32'd2;
  localparam logic [31:0] DEF_BREAK_CODE   = 32'd3;
  localparam logic [31:0] DEF_ECALL_CODE   = 32'd11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    TRAP  = 3'd3,
    MRET  = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] rs1_val;
    logic [4:0]  uimm;
    logic        rd_zero;
    logic [31:0] pc;
  } req_t;

  // Set/clear forms with a zero rs1 field are pure reads.
  function automatic logic is_write_op(input logic [2:0] funct3, input logic [4:0] uimm);
    return (funct3[1:0] == 2'b01) || (uimm != 5'd0);
  endfunction

  // Swap forms targeting x0 skip the read side effect.
  function automatic logic is_read_op(input logic [2:0] funct3, input logic rd_zero);
    return !((funct3[1:0] == 2'b01) && rd_zero);
  endfunction

endpackage

// File: rtl/csr_addr_check.sv
// Address legality decode for CSR instructions; purely combinational, no backpressure.
// Flags unknown addresses and any write to the read-only misa register.
module csr_addr_check
  import csr_pkg::*;
(
  input  logic [11:0] addr,
  input  logic        write_performed,
  output logic        illegal
);

  logic known;

  always_comb begin
    known = 1'b0;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MEPC,
      CSR_MCAUSE, CSR_CYCLE, CSR_INSTRET: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  assign illegal = !known || (write_performed && (addr == CSR_MISA));

endmodule

// File: rtl/csr_access_unit.sv
// Sequences CSR read/modify/write, ECALL/EBREAK/illegal traps and MRET against an external CSR file.
// Latency accept->rsp_valid: 3 cycles read-modify-write, 2 otherwise; one request in flight.
// req_ready only in IDLE; the response holds in DONE until rsp_ready.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] ILLEGAL_CODE = DEF_ILLEGAL_CODE,
  parameter logic [31:0] BREAK_CODE   = DEF_BREAK_CODE,
  parameter logic [31:0] ECALL_CODE   = DEF_ECALL_CODE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_uimm,
  input  logic        req_rd_zero,
  input  logic [31:0] req_pc,
  output logic        csr_read_en,
  output logic        csr_write_en,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_write_data,
  input  logic [31:0] csr_read_data,
  output logic        trap_enter,
  output logic        trap_exit,
  output logic [31:0] current_pc,
  output logic [31:0] exception_code,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_redirect,
  output logic [31:0] rsp_target
);

  state_t      state, state_nxt;
  req_t        req_q;
  logic [31:0] old_q;
  logic [31:0] target_q;
  logic        redirect_q;

  logic        accept;
  logic        new_wr, new_rd, addr_illegal, new_illegal;
  logic        lat_wr;
  logic [31:0] src, wdata, trap_code, trap_target;

  assign accept = req_valid && req_ready;
  assign new_wr = is_write_op(req_funct3, req_uimm);
  assign new_rd = is_read_op(req_funct3, req_rd_zero);

  csr_addr_check u_addr_check (
    .addr            (req_addr),
    .write_performed (new_wr),
    .illegal         (addr_illegal)
  );

  // funct3 000 and 100 are the only encodings with a zero op field.
  assign new_illegal = (req_funct3[1:0] == 2'b00) || addr_illegal;
  assign lat_wr      = is_write_op(req_q.funct3, req_q.uimm);

  assign src = req_q.funct3[2] ? {27'd0, req_q.uimm} : req_q.rs1_val;

  always_comb begin
    wdata = '0;
    case (req_q.funct3[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = old_q | src;
      2'b11:   wdata = old_q & ~src;
      default: wdata = '0;
    endcase
  end

  always_comb begin
    trap_code = ILLEGAL_CODE;
    if (req_q.kind == KIND_ECALL)       trap_code = ECALL_CODE;
    else if (req_q.kind == KIND_EBREAK) trap_code = BREAK_CODE;
  end

  assign trap_target = {mtvec_in[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_kind == KIND_MRET)                         state_nxt = MRET;
          else if ((req_kind != KIND_CSR) || new_illegal)    state_nxt = TRAP;
          else if (new_rd)                                   state_nxt = READ;
          else                                               state_nxt = WRITE;
        end
      end
      READ:              state_nxt = lat_wr ? WRITE : DONE;
      WRITE, TRAP, MRET: state_nxt = DONE;
      DONE:              if (rsp_ready) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    csr_read_en    = 1'b0;
    csr_write_en   = 1'b0;
    csr_addr       = '0;
    csr_write_data = '0;
    trap_enter     = 1'b0;
    trap_exit      = 1'b0;
    current_pc     = '0;
    exception_code = '0;
    rsp_valid      = 1'b0;
    rsp_rd_data    = '0;
    rsp_redirect   = 1'b0;
    rsp_target     = '0;
    case (state)
      IDLE:  req_ready = 1'b1;
      READ: begin
        csr_read_en = 1'b1;
        csr_addr    = req_q.addr;
      end
      WRITE: begin
        csr_write_en   = 1'b1;
        csr_addr       = req_q.addr;
        csr_write_data = wdata;
      end
      TRAP: begin
        trap_enter     = 1'b1;
        current_pc     = req_q.pc;
        exception_code = trap_code;
        rsp_target     = trap_target;
      end
      MRET: begin
        trap_exit  = 1'b1;
        rsp_target = mepc_in;
      end
      DONE: begin
        rsp_valid    = 1'b1;
        rsp_rd_data  = old_q;
        rsp_redirect = redirect_q;
        rsp_target   = target_q;
      end
      default: ;
    endcase
  end

  // old_q is cleared on accept so non-reading ops return 0 for rd.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q      <= '0;
      old_q      <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
    end else begin
      if (accept) begin
        req_q.kind    <= req_kind;
        req_q.funct3  <= req_funct3;
        req_q.addr    <= req_addr;
        req_q.rs1_val <= req_rs1_val;
        req_q.uimm    <= req_uimm;
        req_q.rd_zero <= req_rd_zero;
        req_q.pc      <= req_pc;
        old_q         <= '0;
        target_q      <= '0;
        redirect_q    <= 1'b0;
      end
      if (state == READ) old_q <= csr_read_data;
      if (state == TRAP) begin
        redirect_q <= 1'b1;
        target_q   <= trap_target;
      end
      if (state == MRET) begin
        redirect_q <= 1'b1;
        target_q   <= mepc_in;
      end
    end
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter ILLEGAL_CODE, default 32'd2, which is the mcause value for an illegal CSR instruction.
REQ-002 SHALL have parameter BREAK_CODE, default 32'd3, which is the mcause value for EBREAK.
REQ-003 SHALL have parameter ECALL_CODE, default 32'd11, which is the mcause value for ECALL from M-mode.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1 / req_ready, out, 1: request handshake.
- req_kind, in, 2: 00=CSR, 01=ECALL, 10=EBREAK, 11=MRET.
- req_funct3, in, 3: CSR op. 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_addr, in, 12: CSR address.
- req_rs1_val, in, 32: source value.
- req_uimm, in, 5: immediate, which is also the rs1 field.
- req_rd_zero, in, 1: rd==x0.
- req_pc, in, 32: instruction PC.
- csr_read_en, out, 1 / csr_write_en, out, 1 / csr_addr, out, 12 / csr_write_data, out, 32: CSR-file access.
- csr_read_data, in, 32: combinational read data from the CSR file.
- trap_enter, out, 1 / trap_exit, out, 1 / current_pc, out, 32 / exception_code, out, 32: trap strobes to the CSR file.
- mtvec_in, in, 32 / mepc_in, in, 32: trap vector and return address from the CSR file.
- rsp_valid, out, 1 / rsp_ready, in, 1: response handshake.
- rsp_rd_data, out, 32: old CSR value for rd.
- rsp_redirect, out, 1 / rsp_target, out, 32: PC redirect and its target.

Function
REQ-006 SHALL implement FSM states IDLE, READ, WRITE, TRAP, MRET, DONE, and SHALL assert req_ready only in IDLE.
REQ-007 SHALL latch all req_* fields on the edge where req_valid&&req_ready.
REQ-008 SHALL treat a CSR request as illegal when:
- req_funct3 is 000 or 100; or
- req_addr is not in {300,301,305,341,342,C00,C02}; or
- the request performs a write and req_addr==301 (misa is read-only).
REQ-009 SHALL define "write performed" as: RW/RWI always; RS/RC/RSI/RCI only when req_uimm!=0.
REQ-010 SHALL define "read performed" as every legal CSR op except RW/RWI with req_rd_zero=1.
REQ-011 SHALL take these transitions from IDLE on accept:
- illegal CSR, ECALL or EBREAK -> TRAP;
- MRET -> MRET;
- read performed -> READ;
- otherwise -> WRITE.
REQ-012 SHALL, in READ, assert csr_read_en for exactly one cycle with csr_addr=latched address, capture csr_read_data into an old-value register, then go to WRITE if a write is performed, else to DONE.
REQ-013 SHALL, in WRITE, assert csr_write_en for exactly one cycle, then go to DONE.
REQ-014 SHALL form csr_write_data from src (rs1_val for register forms, zero-extended uimm for immediate forms) as follows:
- RW: src.
- RS: old|src.
- RC: old&~src.
REQ-015 SHALL, in TRAP, assert trap_enter for exactly one cycle with current_pc=latched PC, exception_code=ILLEGAL_CODE, BREAK_CODE or ECALL_CODE as applicable, and rsp_target={mtvec_in[31:2],2'b00}, then go to DONE.
REQ-016 SHALL, in MRET, assert trap_exit for exactly one cycle with rsp_target=mepc_in captured that cycle, then go to DONE.
REQ-017 SHALL, in DONE, hold rsp_valid=1 and keep rsp_rd_data, rsp_redirect and rsp_target stable until rsp_ready=1, then return to IDLE.
REQ-018 SHALL set rsp_rd_data=old value when a read is performed, else 0.
REQ-019 SHALL set rsp_redirect=1 only for TRAP and MRET.
REQ-020 SHALL have these latencies from the accept edge to rsp_valid: 3 cycles for a CSR read-modify-write, 2 cycles for read-only or write-only, 2 cycles for trap or MRET.
REQ-021 SHALL keep csr_read_en, csr_write_en, trap_enter and trap_exit mutually exclusive and never asserted in IDLE or DONE.
REQ-022 SHALL drive csr_addr, csr_write_data, current_pc and exception_code to 0 in any state where they are not in use.

Reset
REQ-023 SHALL, while reset_n=0, force the state to IDLE and all registers to 0, regardless of state, including mid-operation.
REQ-024 SHALL therefore drive every strobe, rsp_valid and every data output to 0 during reset, and drive req_ready to 1 during reset.
REQ-025 SHALL make no CSR access after reset deassertion until a new request is accepted.

Structure
REQ-026 SHALL place the CSR address constants, funct3 and req_kind encodings, default exception codes and the FSM state encoding in the shared package csr_pkg.
REQ-027 SHALL use the combinational sub-module csr_addr_check (inputs addr and write_performed; output illegal) for legality decode.

Verification
REQ-028 Bench SHALL cover CSRRW, addr 305, rs1_val=0x100, rd!=x0, mtvec=0 -> read cycle, then write 0x100, rsp_rd_data=0, rsp_redirect=0, rsp_valid 3 cycles after accept.
REQ-029 Bench SHALL cover CSRRS, addr 300, uimm=0, mstatus=0x1888 -> read only with no csr_write_en, rsp_rd_data=0x1888.
REQ-030 Bench SHALL cover CSRRCI, addr 300, uimm=0x08, mstatus=0x88 -> csr_write_data=0x80.
REQ-031 Bench SHALL cover CSRRW to 301, and separately CSRRS to 0x7C0 with uimm=1 -> trap_enter, exception_code=2, current_pc=req_pc, no csr_write_en, rsp_target=mtvec&~3.
REQ-032 Bench SHALL cover ECALL at pc 0x40 with mtvec=0x201, then MRET with mepc=0x40 -> ECALL gives target 0x200 and code 11; MRET gives trap_exit and target 0x40.
REQ-033 Bench SHALL cover reset_n low during WRITE, and separately rsp_ready held low for 5 cycles -> reset gives all strobes 0 immediately and req_ready=1; held rsp_ready gives outputs stable for 5 cycles.
